// File: rtl/mm_arb_pkg.sv
// Shared types and constants for the MM register-bus arbiter.
// The command record is sized to the link decoder's 17-bit address / 64-bit data bus.
package mm_arb_pkg;

  localparam int unsigned MM_ADDR_W   = 17;
  localparam int unsigned MM_DATA_W   = 64;
  localparam logic [31:0] TIMEOUT_TAG = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  typedef struct packed {
    logic                 wr;
    logic [MM_ADDR_W-1:0] addr;
    logic [MM_DATA_W-1:0] data;
  } mm_cmd_t;

endpackage

// File: rtl/mm_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first pending master
// at or after the pointer, plus its index. The pointer is owned by the caller.
module mm_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic        found;
  int unsigned j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr_i) + i) % NUM_REQ;
      if (!found && pending_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mm_bus_arbiter.sv
// Round-robin arbiter sharing one MM register bus among NUM_REQ masters,
// with one transaction in flight, read-response routing and read timeout.
module mm_bus_arbiter
  import mm_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = MM_ADDR_W,
  parameter int unsigned DATA_W  = MM_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_wr_en,
  input  logic [NUM_REQ-1:0]        req_rd_en,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         req_rd_data,
  output logic [NUM_REQ-1:0]        req_rd_data_v,
  output logic                      oMM_WR_EN,
  output logic                      oMM_RD_EN,
  output logic [ADDR_W-1:0]         oMM_ADDR,
  output logic [DATA_W-1:0]         oMM_WR_DATA,
  input  logic [DATA_W-1:0]         iMM_RD_DATA,
  input  logic                      iMM_RD_DATA_V,
  output logic                      rd_timeout,
  output logic [15:0]               timeout_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  mm_cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  rdv_q, rdv_d;
  logic                tmo_q, tmo_d;
  logic [15:0]         tcnt_q, tcnt_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   tmo_data;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] w);
    return (32'(w) == NUM_REQ - 1) ? '0 : w + 1'b1;
  endfunction

  mm_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .pending_i (req_wr_en | req_rd_en),
    .ptr_i     (ptr_q),
    .grant_o   (gnt),
    .idx_o     (gnt_idx)
  );

  // Write takes priority when a master raises both; its read stays pending.
  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_wr   = req_wr_en[i];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    tcnt_d  = tcnt_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    ack_d   = '0;
    rdv_d   = '0;
    tmo_d   = 1'b0;

    tmo_data                   = '0;
    tmo_data[ADDR_W-1:0]       = cmd_q.addr;
    tmo_data[DATA_W-1 -: 32]   = TIMEOUT_TAG;

    unique case (state_q)
      // Strobe/ack registers load on entry to ISSUE so they are live exactly that cycle.
      IDLE: begin
        if (|gnt) begin
          win_d      = gnt_idx;
          cmd_d.wr   = sel_wr;
          cmd_d.addr = sel_addr;
          cmd_d.data = sel_data;
          wr_en_d    = sel_wr;
          rd_en_d    = !sel_wr;
          addr_d     = sel_addr;
          wdata_d    = sel_wr ? sel_data : '0;
          ack_d      = gnt;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_q.wr) begin
          ptr_d   = rr_next(win_q);
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (iMM_RD_DATA_V) begin
          rdata_d       = iMM_RD_DATA;
          rdv_d[win_q]  = 1'b1;
          ptr_d         = rr_next(win_q);
          state_d       = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rdata_d       = tmo_data;
          rdv_d[win_q]  = 1'b1;
          tmo_d         = 1'b1;
          tcnt_d        = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
          ptr_d         = rr_next(win_q);
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      rdv_q   <= '0;
      tmo_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      tmo_q   <= tmo_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign oMM_WR_EN     = wr_en_q;
  assign oMM_RD_EN     = rd_en_q;
  assign oMM_ADDR      = addr_q;
  assign oMM_WR_DATA   = wdata_q;
  assign req_ack       = ack_q;
  assign req_rd_data   = rdata_q;
  assign req_rd_data_v = rdv_q;
  assign rd_timeout    = tmo_q;
  assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter: vector table for single transactions plus
// hand-written sequences for round-robin, priority, timeout and reset corners.
module tb_mm_bus_arbiter;

  localparam int NR = 2;
  localparam int AW = 17;
  localparam int DW = 64;
  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_wr_en, req_rd_en;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wr_data;
  logic [NR-1:0]     req_ack;
  logic [DW-1:0]     req_rd_data;
  logic [NR-1:0]     req_rd_data_v;
  logic              oMM_WR_EN, oMM_RD_EN;
  logic [AW-1:0]     oMM_ADDR;
  logic [DW-1:0]     oMM_WR_DATA;
  logic [DW-1:0]     iMM_RD_DATA;
  logic              iMM_RD_DATA_V;
  logic              rd_timeout;
  logic [15:0]       timeout_cnt;

  always #5 clk = ~clk;

  mm_bus_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_wr_en     (req_wr_en),
    .req_rd_en     (req_rd_en),
    .req_addr      (req_addr),
    .req_wr_data   (req_wr_data),
    .req_ack       (req_ack),
    .req_rd_data   (req_rd_data),
    .req_rd_data_v (req_rd_data_v),
    .oMM_WR_EN     (oMM_WR_EN),
    .oMM_RD_EN     (oMM_RD_EN),
    .oMM_ADDR      (oMM_ADDR),
    .oMM_WR_DATA   (oMM_WR_DATA),
    .iMM_RD_DATA   (iMM_RD_DATA),
    .iMM_RD_DATA_V (iMM_RD_DATA_V),
    .rd_timeout    (rd_timeout),
    .timeout_cnt   (timeout_cnt)
  );

  // Downstream model: replies mdl_delay cycles after the read strobe (0 = never).
  int            mdl_delay = 3;
  int            mdl_cnt   = 0;
  logic          mdl_pend  = 1'b0;
  logic          mdl_v     = 1'b0;
  logic [DW-1:0] mdl_d     = '0;
  logic          stray_v   = 1'b0;
  logic [DW-1:0] stray_d   = '0;

  always @(posedge clk) begin
    mdl_v <= 1'b0;
    if (mdl_pend) begin
      if (mdl_cnt == 1) begin
        mdl_v    <= 1'b1;
        mdl_pend <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
    if (oMM_RD_EN && mdl_delay != 0) begin
      mdl_pend <= 1'b1;
      mdl_cnt  <= mdl_delay - 1;
      mdl_d    <= {47'b0, oMM_ADDR};
    end
  end

  assign iMM_RD_DATA_V = mdl_v | stray_v;
  assign iMM_RD_DATA   = stray_v ? stray_d : mdl_d;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    req_wr_en   = '0;
    req_rd_en   = '0;
    req_addr    = '0;
    req_wr_data = '0;
  endtask

  task automatic set_req(input int m, input logic wr, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr_en[m]          = wr;
    req_rd_en[m]          = rd;
    req_addr[m*AW +: AW]  = a;
    req_wr_data[m*DW +: DW] = d;
  endtask

  typedef struct {
    int           mst;
    logic         wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int           dly;
    logic [NR-1:0] exp_ack;
    logic [DW-1:0] exp_rdata;
    logic [NR-1:0] exp_rdv;
    int           exp_lat;
  } vec_t;

  vec_t vecs[6];

  // One transaction: strobe/ack at +1, quiet at +2, read data after exp_lat cycles.
  task automatic run_vec(input vec_t v);
    int lat;
    mdl_delay = v.dly;
    set_req(v.mst, v.wr, !v.wr, v.addr, v.wdata);
    tick();
    chk("issue_wr_en", oMM_WR_EN, v.wr);
    chk("issue_rd_en", oMM_RD_EN, !v.wr);
    chk("issue_addr", oMM_ADDR, v.addr);
    chk("issue_ack", req_ack, v.exp_ack);
    if (v.wr) chk("issue_wdata", oMM_WR_DATA, v.wdata);
    clr_req();
    tick();
    chk("ack_one_cycle", req_ack, 0);
    chk("strobes_off", {oMM_WR_EN, oMM_RD_EN}, 0);
    chk("addr_off", oMM_ADDR, 0);
    if (!v.wr) begin
      lat = 2;
      while (req_rd_data_v == '0 && lat < 40) begin
        tick();
        lat++;
      end
      chk("rd_latency", lat, v.exp_lat);
      chk("rd_valid", req_rd_data_v, v.exp_rdv);
      chk("rd_data", req_rd_data, v.exp_rdata);
      chk("rd_no_timeout", rd_timeout, 0);
      tick();
      chk("rd_valid_pulse", req_rd_data_v, 0);
      chk("rd_data_hold", req_rd_data, v.exp_rdata);
    end else begin
      tick();
    end
  endtask

  // Long read that ends either by timeout or by a reply landing on the timeout cycle.
  task automatic run_long(input int m, input logic [AW-1:0] a, input int dly,
                          input logic [DW-1:0] exp_d, input logic exp_tmo,
                          input logic [15:0] exp_tcnt);
    int lat;
    mdl_delay = dly;
    set_req(m, 1'b0, 1'b1, a, '0);
    tick();
    chk("long_rd_en", oMM_RD_EN, 1);
    clr_req();
    lat = 1;
    while (req_rd_data_v == '0 && lat < 300) begin
      tick();
      lat++;
    end
    chk("long_latency", lat, TO + 3);
    chk("long_rd_valid", req_rd_data_v, NR'(1) << m);
    chk("long_rd_data", req_rd_data, exp_d);
    chk("long_timeout_pulse", rd_timeout, exp_tmo);
    chk("long_timeout_cnt", timeout_cnt, exp_tcnt);
    tick();
    chk("long_timeout_clear", rd_timeout, 0);
    chk("long_valid_clear", req_rd_data_v, 0);
  endtask

  logic [NR-1:0] rr_ack [8];
  logic [AW-1:0] rr_addr[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   lat;

    vecs[0] = '{0, 1'b1, 17'h0_0010, 64'h1234,                0, 2'b01, 64'h0,      2'b00, 0};
    vecs[1] = '{1, 1'b0, 17'h0_4020, 64'h0,                   3, 2'b10, 64'h4020,   2'b10, 5};
    vecs[2] = '{0, 1'b0, 17'h0_0ABC, 64'h0,                   3, 2'b01, 64'hABC,    2'b01, 5};
    vecs[3] = '{1, 1'b1, 17'h1_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2'b10, 64'h0,      2'b00, 0};
    vecs[4] = '{1, 1'b0, 17'h1_2345, 64'h0,                   7, 2'b10, 64'h1_2345, 2'b10, 9};
    vecs[5] = '{1, 1'b1, 17'h0_0001, 64'hA5A5_0000_0000_5A5A, 0, 2'b10, 64'h0,      2'b00, 0};

    rr_ack  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    rr_addr = '{17'h0_00A0, 17'h0, 17'h0_00B1, 17'h0, 17'h0_00A0, 17'h0, 17'h0_00B1, 17'h0};

    rst = 1'b1;
    clr_req();
    repeat (3) tick();
    chk("rst_ack", req_ack, 0);
    chk("rst_strobes", {oMM_WR_EN, oMM_RD_EN, rd_timeout}, 0);
    chk("rst_addr", oMM_ADDR, 0);
    chk("rst_wdata", oMM_WR_DATA, 0);
    chk("rst_rdata", req_rd_data, 0);
    chk("rst_rdv", req_rd_data_v, 0);
    chk("rst_tcnt", timeout_cnt, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both masters hold writes: grants must alternate starting from master 0.
    set_req(0, 1'b1, 1'b0, 17'h0_00A0, 64'hA0);
    set_req(1, 1'b1, 1'b0, 17'h0_00B1, 64'hB1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_ack", req_ack, rr_ack[i]);
      chk("rr_addr", oMM_ADDR, rr_addr[i]);
    end
    clr_req();
    tick();

    // Write+read from one master: write first, read in a later round.
    mdl_delay = 3;
    set_req(0, 1'b1, 1'b1, 17'h0_0055, 64'h55);
    tick();
    chk("prio_wr_first", {oMM_WR_EN, oMM_RD_EN}, 2'b10);
    chk("prio_ack1", req_ack, 2'b01);
    req_wr_en = '0;
    tick();
    chk("prio_gap", {oMM_WR_EN, oMM_RD_EN}, 2'b00);
    tick();
    chk("prio_rd_second", {oMM_WR_EN, oMM_RD_EN}, 2'b01);
    chk("prio_ack2", req_ack, 2'b01);
    chk("prio_rd_addr", oMM_ADDR, 17'h0_0055);
    clr_req();
    lat = 3;
    while (req_rd_data_v == '0 && lat < 40) begin
      tick();
      lat++;
    end
    chk("prio_rd_latency", lat, 7);
    chk("prio_rd_data", req_rd_data, 64'h55);
    chk("prio_rd_valid", req_rd_data_v, 2'b01);
    tick();

    // Timeout with no reply, then a stray late valid that must be ignored.
    run_long(0, 17'h1_8000, 0, 64'hDEAD_BEEF_0001_8000, 1'b1, 16'd1);
    stray_d = 64'hBAD0_BAD0_BAD0_BAD0;
    stray_v = 1'b1;
    tick();
    stray_v = 1'b0;
    tick();
    chk("stray_rdv", req_rd_data_v, 0);
    chk("stray_rdata_hold", req_rd_data, 64'hDEAD_BEEF_0001_8000);
    chk("stray_tcnt", timeout_cnt, 1);

    // Reply on the exact timeout cycle: data wins, no timeout recorded.
    run_long(1, 17'h0_0777, TO + 1, 64'h777, 1'b0, 16'd1);

    // Reset while waiting for read data aborts the transaction.
    mdl_delay = 3;
    set_req(1, 1'b0, 1'b1, 17'h0_0123, '0);
    tick();
    chk("rstmid_rd_en", oMM_RD_EN, 1);
    clr_req();
    tick();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_ack", req_ack, 0);
    chk("rstmid_strobes", {oMM_WR_EN, oMM_RD_EN, rd_timeout}, 0);
    chk("rstmid_rdata", req_rd_data, 0);
    chk("rstmid_tcnt", timeout_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_no_rdv", req_rd_data_v, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_rdv", req_rd_data_v, 0);
    end
    v = '{0, 1'b0, 17'h0_0321, 64'h0, 3, 2'b01, 64'h321, 2'b01, 5};
    run_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
